// File: rtl/restoring_divider.sv
// Triple-modular-redundant 16/8 unsigned restoring divider.
// Three independent lanes compute the same division; q, rem, busy, done and
// err are the bitwise 2-of-3 majority of the lane outputs, and mism flags any
// lane disagreement on those bits.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   start, r, b    - division request, 16-bit dividend, 8-bit divisor
//   q, rem, err    - voted quotient, remainder, error flag (held between results)
//   busy, done     - voted busy level and one-cycle result-valid pulse
//   mism           - combinational lane-disagreement flag

// Single divider lane: IDLE/RUN/DONE FSM, 3-bit counter, 9-bit partial remainder.
module restoring_divider_lane (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] r,
  input  logic [7:0]  b,
  output logic [7:0]  q,
  output logic [7:0]  rem,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = DW + 1;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [PW-1:0]   prem, prem_nxt;
  logic [DW-1:0]   dvd, dvd_nxt;
  logic [DW-1:0]   dvs, dvs_nxt;
  logic [DW-1:0]   qw, qw_nxt;
  logic [DW-1:0]   q_r, q_nxt;
  logic [DW-1:0]   rem_r, rem_nxt;
  logic            err_r, err_nxt;
  logic            done_r, done_nxt;
  logic            busy_r, busy_nxt;
  logic            start_err;
  logic [PW:0]     shifted;
  logic [PW:0]     diff;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      prem   <= '0;
      dvd    <= '0;
      dvs    <= '0;
      qw     <= '0;
      q_r    <= '0;
      rem_r  <= '0;
      err_r  <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      prem   <= prem_nxt;
      dvd    <= dvd_nxt;
      dvs    <= dvs_nxt;
      qw     <= qw_nxt;
      q_r    <= q_nxt;
      rem_r  <= rem_nxt;
      err_r  <= err_nxt;
      done_r <= done_nxt;
      busy_r <= busy_nxt;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    prem_nxt  = prem;
    dvd_nxt   = dvd;
    dvs_nxt   = dvs;
    qw_nxt    = qw;
    q_nxt     = q_r;
    rem_nxt   = rem_r;
    err_nxt   = err_r;
    done_nxt  = 1'b0;

    // Quotient would not fit in 8 bits when the upper dividend byte >= divisor
    start_err = (b == '0) || (r[15:8] >= b);
    // Trial subtraction; bit PW of diff is the borrow (negative result)
    shifted   = {prem, dvd[DW-1]};
    diff      = shifted - (PW+1)'(dvs);

    case (state)
      S_IDLE: begin
        if (start) begin
          if (start_err) begin
            state_nxt = S_DONE;
            q_nxt     = 8'hFF;
            rem_nxt   = 8'h00;
            err_nxt   = 1'b1;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_RUN;
            cnt_nxt   = CW'(DW - 1);
            prem_nxt  = {1'b0, r[15:8]};
            dvd_nxt   = r[7:0];
            dvs_nxt   = b;
            qw_nxt    = '0;
          end
        end
      end
      S_RUN: begin
        dvd_nxt = {dvd[DW-2:0], 1'b0};
        if (!diff[PW]) begin
          prem_nxt = diff[PW-1:0];
          qw_nxt   = {qw[DW-2:0], 1'b1};
        end else begin
          prem_nxt = shifted[PW-1:0];
          qw_nxt   = {qw[DW-2:0], 1'b0};
        end
        cnt_nxt = cnt - CW'(1);
        if (cnt == '0) begin
          state_nxt = S_DONE;
          q_nxt     = qw_nxt;
          rem_nxt   = prem_nxt[DW-1:0];
          err_nxt   = 1'b0;
          done_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

  assign q    = q_r;
  assign rem  = rem_r;
  assign err  = err_r;
  assign done = done_r;
  assign busy = busy_r;

endmodule

// Top level: three lanes plus majority voter and mismatch detector.
module restoring_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] r,
  input  logic [7:0]  b,
  output logic [7:0]  q,
  output logic [7:0]  rem,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mism
);

  localparam int unsigned VW = 19;

  logic [7:0] q0, q1, q2;
  logic [7:0] rem0, rem1, rem2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       err0, err1, err2;
  logic [VW-1:0] v0, v1, v2, voted;

  (* keep = "true", dont_touch = "true" *)
  restoring_divider_lane u_lane0 (
    .clk(clk), .rst(rst), .start(start), .r(r), .b(b),
    .q(q0), .rem(rem0), .busy(busy0), .done(done0), .err(err0)
  );

  (* keep = "true", dont_touch = "true" *)
  restoring_divider_lane u_lane1 (
    .clk(clk), .rst(rst), .start(start), .r(r), .b(b),
    .q(q1), .rem(rem1), .busy(busy1), .done(done1), .err(err1)
  );

  (* keep = "true", dont_touch = "true" *)
  restoring_divider_lane u_lane2 (
    .clk(clk), .rst(rst), .start(start), .r(r), .b(b),
    .q(q2), .rem(rem2), .busy(busy2), .done(done2), .err(err2)
  );

  // Bitwise 2-of-3 vote over all lane outputs packed side by side
  assign v0    = {q0, rem0, busy0, done0, err0};
  assign v1    = {q1, rem1, busy1, done1, err1};
  assign v2    = {q2, rem2, busy2, done2, err2};
  assign voted = (v0 & v1) | (v0 & v2) | (v1 & v2);

  assign {q, rem, busy, done, err} = voted;
  assign mism = |((v0 ^ v1) | (v0 ^ v2));

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed cases, reset abort,
// lane fault masking and randomized divisions against an arithmetic model.
module tb_restoring_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] r;
  logic [7:0]  b;
  logic [7:0]  q;
  logic [7:0]  rem;
  logic        busy;
  logic        done;
  logic        err;
  logic        mism;

  int compared   = 0;
  int mismatched = 0;

  restoring_divider dut (
    .clk(clk), .rst(rst), .start(start), .r(r), .b(b),
    .q(q), .rem(rem), .busy(busy), .done(done), .err(err), .mism(mism)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer division; error when b==0 or quotient > 255
  function automatic void model(input logic [15:0] rv, input logic [7:0] bv,
                                output logic [7:0] eq, output logic [7:0] erem,
                                output logic eerr);
    int unsigned ri, bi;
    ri = 32'(rv);
    bi = 32'(bv);
    if (bi == 0 || (ri / bi) > 255) begin
      eq = 8'hFF; erem = 8'h00; eerr = 1'b1;
    end else begin
      eq = 8'(ri / bi); erem = 8'(ri % bi); eerr = 1'b0;
    end
  endfunction

  // Issue one division, optionally re-pulse start with other operands mid-run
  task automatic run_div(input logic [15:0] rv, input logic [7:0] bv,
                         input logic exp_mism, input logic repulse);
    logic [7:0] eq, erem, prev_q, prev_rem;
    logic       eerr;
    logic       stable;
    int         lat, busy_cnt, exp_lat;
    model(rv, bv, eq, erem, eerr);
    exp_lat  = eerr ? 0 : 8;
    prev_q   = q;
    prev_rem = rem;
    stable   = 1'b1;
    lat      = 0;
    busy_cnt = 0;
    start = 1'b1; r = rv; b = bv;
    tick();
    start = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (q !== prev_q || rem !== prev_rem) stable = 1'b0;
      tick();
      lat++;
      if (repulse) begin
        start = (lat == 2);
        if (lat == 2) begin
          r = ~rv;
          b = bv + 8'd1;
        end
      end
    end
    start = 1'b0;
    if (busy === 1'b1) busy_cnt++;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_cycles", 32'(busy_cnt), 32'(exp_lat + 1));
    chk("held_before_done", 32'(stable), 32'd1);
    chk("q", 32'(q), 32'(eq));
    chk("rem", 32'(rem), 32'(erem));
    chk("err", 32'(err), 32'(eerr));
    chk("mism_at_done", 32'(mism), 32'(exp_mism));
    tick();
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("q_held", 32'(q), 32'(eq));
  endtask

  initial begin
    logic [15:0] rv;
    logic [7:0]  bv;

    rst = 1'b1; start = 1'b0; r = '0; b = '0;
    repeat (3) tick();
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mism", 32'(mism), 32'd0);
    rst = 1'b0;
    tick();

    // Nominal, divide-by-zero, overflow and maximal-quotient cases
    run_div(16'd1000, 8'd7, 1'b0, 1'b0);
    run_div(16'h0050, 8'h00, 1'b0, 1'b0);
    run_div(16'h1234, 8'h12, 1'b0, 1'b0);
    run_div(16'hFE01, 8'hFF, 1'b0, 1'b0);

    // Start re-pulsed while running is ignored; the following call is back-to-back
    run_div(16'd1000, 8'd7, 1'b0, 1'b1);
    run_div(16'd517, 8'd13, 1'b0, 1'b0);

    // Reset during the 4th RUN cycle aborts with no done pulse
    start = 1'b1; r = 16'd1000; b = 8'd7;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_rem", 32'(rem), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (10) begin
      tick();
      chk("no_done_after_abort", 32'(done), 32'd0);
    end
    run_div(16'd200, 8'd9, 1'b0, 1'b0);

    // A single lane with a stuck quotient is outvoted and flagged
    force dut.u_lane0.q_r = 8'h00;
    #1;
    chk("mism_forced", 32'(mism), 32'd1);
    run_div(16'd1000, 8'd7, 1'b1, 1'b0);
    release dut.u_lane0.q_r;
    run_div(16'd300, 8'd20, 1'b0, 1'b0);

    // Randomized divisions, biased toward non-overflowing operands
    for (int i = 0; i < 40; i++) begin
      bv = 8'($urandom_range(0, 255));
      if (bv != 8'd0 && $urandom_range(0, 3) != 0)
        rv = {8'($urandom_range(0, 32'(bv) - 1)), 8'($urandom)};
      else
        rv = 16'($urandom);
      run_div(rv, bv, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL: clk  input  1  -- single clock; all state updates on the rising edge.
REQ-002 SHALL: rst  input  1  -- reset, asynchronous, active-high.
REQ-003 SHALL: start  input  1  -- request a division; sampled only while busy=0.
REQ-004 SHALL: r  input  16  -- unsigned dividend; sampled with start.
REQ-005 SHALL: b  input  8  -- unsigned divisor; sampled with start.
REQ-006 SHALL: q  output  8  -- quotient, registered, held until the next accepted start.
REQ-007 SHALL: rem  output  8  -- remainder, registered, held until the next accepted start.
REQ-008 SHALL: busy  output  1  -- high whenever the voted state is not IDLE.
REQ-009 SHALL: done  output  1  -- one-cycle pulse marking q/rem/err valid.
REQ-010 SHALL: err  output  1  -- divide-by-zero or quotient overflow; registered with done, held with q.
REQ-011 SHALL: mism  output  1  -- combinational; high when any lane disagrees on any voted output bit.

Function
REQ-012 SHALL: Three identical, independent lanes, each with its own FSM, counter and datapath.
- All lanes receive the same clk, rst, start, r and b.
- Lanes carry a synthesis keep/don't-touch attribute so they are not merged.
REQ-013 SHALL: q, rem, busy, done and err are the bitwise 2-of-3 majority of the lane outputs: (x&y)|(x&z)|(y&z).
REQ-014 SHALL: Each lane FSM has three states: IDLE, RUN, DONE.
REQ-015 SHALL: Transitions:
- IDLE -> RUN on start with no error.
- IDLE -> DONE on start with error.
- RUN -> DONE after the 8th iteration.
- DONE -> IDLE unconditionally.
REQ-016 SHALL: start is ignored while the FSM is in RUN or DONE; no queuing.
REQ-017 SHALL: Error condition, evaluated on the start edge: b==0 OR r[15:8]>=b.
- Lane enters DONE directly.
- q=8'hFF, rem=8'h00, err=1.
REQ-018 SHALL: Algorithm is a restoring divide with a 9-bit partial remainder and a 3-bit iteration counter (7 down to 0).
- Each RUN cycle shifts in the next dividend bit, MSB first.
- The divisor is subtracted if the result is non-negative; the quotient bit is set accordingly.
REQ-019 SHALL: Partial remainder is initialised to {1'b0, r[15:8]}; the dividend bits consumed are r[7:0].
- Final results satisfy r == q*b + rem and rem < b.
REQ-020 SHALL: Latency: if start is sampled at edge N, done is high for exactly the cycle after edge N+8.
- Error path: done is high for the cycle after edge N.
REQ-021 SHALL: q, rem and err update only on the edge that sets done; they are stable at all other times.
REQ-022 SHALL: busy rises the cycle after the accepted start and falls the cycle after done.
- A new start is accepted at the first edge where busy=0.
REQ-023 SHALL: mism has no effect on the voted outputs; a single faulty lane is fully masked.

Reset
REQ-024 SHALL: While rst=1, every lane is forced to:
- state IDLE, counter=0, partial remainder=0;
- q=0, rem=0, done=0, err=0, busy=0.
REQ-025 SHALL: rst asserted mid-RUN aborts the operation.
- No done pulse is produced.
- q/rem revert to 0.
- Operation resumes on the first edge after rst deasserts, with the FSM in IDLE.
REQ-026 SHALL: After reset with no faults, mism=0.

Verification
REQ-027 SHALL: r=16'd1000, b=8'd7, start at edge N -> done only in the cycle after edge N+8; q=142, rem=6, err=0; busy high for 9 cycles.
REQ-028 SHALL: r=16'h0050, b=8'h00 -> done in the cycle after the start edge; err=1, q=8'hFF, rem=8'h00.
REQ-029 SHALL: r=16'h1234, b=8'h12 (overflow) -> err=1, q=8'hFF, rem=8'h00; r=16'hFE01, b=8'hFF -> err=0, q=8'hFF, rem=8'h00.
REQ-030 SHALL: Re-pulse start with different operands during RUN -> ignored; original result delivered.
- Back-to-back start on the first busy=0 edge -> accepted.
REQ-031 SHALL: Assert rst at the 4th RUN cycle of 1000/7 -> busy=0 and q=rem=0 immediately; no done pulse.
- Next division 200/9 -> q=22, rem=2.
REQ-032 SHALL: Force one lane's q register to 8'h00 during 1000/7 -> voted q=142, mism=1.
- Release the force and run the next clean division -> mism=0.
